// File: rtl/gl_drive_unit_if.sv
// Bus bundle between the GL drive unit and its controller.
// The controller side drives the sync, divider and per-channel controls.
// The drive unit side returns the pad-facing GL clock, the GL reset and the alignment flag.
interface gl_drive_unit_if #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 8
);
  logic                 sync;
  logic [DIV_WIDTH-1:0] div;
  logic [CHANNELS-1:0]  ch_en;
  logic [CHANNELS-1:0]  rst_req;
  logic [CHANNELS-1:0]  gl_clk;
  logic [CHANNELS-1:0]  gl_nrst;
  logic                 aligned;

  modport master (
    output sync,
    output div,
    output ch_en,
    output rst_req,
    input  gl_clk,
    input  gl_nrst,
    input  aligned
  );

  modport slave (
    input  sync,
    input  div,
    input  ch_en,
    input  rst_req,
    output gl_clk,
    output gl_nrst,
    output aligned
  );
endinterface

// File: rtl/gl_drive_unit.sv
// GL clock and reset generator for CHANNELS downstream GL links.
// One programmable half-period divider produces a shared GL clock phase.
// A rising edge of sync re-aligns that phase.
// Each channel gates the clock with its enable.
// Each channel also runs a reset sequencer: it holds gl_nrst low for
// RST_PERIODS GL rising edges, then releases on the next GL falling edge.
module gl_drive_unit #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int RST_PERIODS = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  gl_drive_unit_if.slave       gl_if
);

  // rcnt is 5 bits wide, so RST_PERIODS must lie in 1..32.
  localparam logic [4:0] RCNT_LAST = 5'(RST_PERIODS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_RUN    = 2'd2
  } ch_state_e;

  // Divider and alignment state
  logic                 sync_q;
  logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
  logic [DIV_WIDTH-1:0] div_q,   div_d;
  logic                 phase_q, phase_d;
  logic                 aligned_q, aligned_d;
  logic [CHANNELS-1:0]  gl_clk_q, gl_clk_d;

  // Shared edge events seen by every channel sequencer
  logic sync_rise_s;
  logic tc_s;
  logic rise_evt_s;
  logic fall_evt_s;

  logic [CHANNELS-1:0] gl_nrst_s;

  // Decode sync rise, terminal count and GL clock edge events
  always_comb begin
    sync_rise_s = gl_if.sync & ~sync_q;
    tc_s        = (cnt_q == div_q);
    // A sync rise overrides the terminal count. A rise that sync cancels is therefore not a GL rising edge.
    rise_evt_s  = tc_s & ~phase_q & ~sync_rise_s;
    // A sync rise while the phase is high pulls the clock low, so it counts as a falling edge.
    fall_evt_s  = phase_q & (tc_s | sync_rise_s);
  end

  // Next-state logic for the divider, the alignment flag and the gated clock outputs
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    phase_d   = phase_q;
    aligned_d = aligned_q;
    if (sync_rise_s) begin
      cnt_d     = {DIV_WIDTH{1'b0}};
      phase_d   = 1'b0;
      div_d     = gl_if.div;
      aligned_d = 1'b1;
    end else if (tc_s) begin
      // The new divider is taken only at a half-period boundary, so the current half always completes.
      cnt_d   = {DIV_WIDTH{1'b0}};
      phase_d = ~phase_q;
      div_d   = gl_if.div;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
    gl_clk_d = {CHANNELS{phase_q}} & gl_if.ch_en;
  end

  // Divider, sync edge detector, alignment flag and clock output registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q    <= 1'b0;
      cnt_q     <= {DIV_WIDTH{1'b0}};
      div_q     <= gl_if.div;
      phase_q   <= 1'b0;
      aligned_q <= 1'b0;
      gl_clk_q  <= {CHANNELS{1'b0}};
    end else begin
      sync_q    <= gl_if.sync;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      aligned_q <= aligned_d;
      gl_clk_q  <= gl_clk_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    ch_state_e  state_q;
    logic [4:0] rcnt_q;
    logic       nrst_out_q;

    // Per-channel reset sequencer with a registered gl_nrst output
    always_ff @(posedge clk) begin
      if (!nrst) begin
        state_q    <= ST_ASSERT;
        rcnt_q     <= 5'd0;
        nrst_out_q <= 1'b0;
      end else if (gl_if.rst_req[gi] || !gl_if.ch_en[gi]) begin
        // A request or a disable overrides any edge event in the same cycle.
        state_q    <= ST_ASSERT;
        rcnt_q     <= 5'd0;
        nrst_out_q <= 1'b0;
      end else begin
        nrst_out_q <= (state_q == ST_RUN);
        case (state_q)
          ST_ASSERT: begin
            if (rise_evt_s) begin
              if (rcnt_q == RCNT_LAST) begin
                state_q <= ST_ALIGN;
                rcnt_q  <= rcnt_q;
              end else begin
                state_q <= ST_ASSERT;
                rcnt_q  <= rcnt_q + 5'd1;
              end
            end else begin
              state_q <= ST_ASSERT;
              rcnt_q  <= rcnt_q;
            end
          end
          ST_ALIGN: begin
            rcnt_q <= rcnt_q;
            if (fall_evt_s) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_ALIGN;
            end
          end
          ST_RUN: begin
            rcnt_q  <= rcnt_q;
            state_q <= ST_RUN;
          end
          default: begin
            // Recover from an illegal encoding with a fresh reset sequence.
            state_q <= ST_ASSERT;
            rcnt_q  <= 5'd0;
          end
        endcase
      end
    end

    assign gl_nrst_s[gi] = nrst_out_q;
  end

  assign gl_if.gl_clk  = gl_clk_q;
  assign gl_if.gl_nrst = gl_nrst_s;
  assign gl_if.aligned = aligned_q;

endmodule

// File: tb/tb_gl_drive_unit.sv
// Directed bench for gl_drive_unit (CHANNELS=4, DIV_WIDTH=8, RST_PERIODS=16).
// Inputs change and outputs are sampled 1 time unit after a rising clock edge.
// Edge numbers in comments count rising edges from a reference point.
module tb_gl_drive_unit;

  localparam int CHANNELS    = 4;
  localparam int DIV_WIDTH   = 8;
  localparam int RST_PERIODS = 16;

  logic clk;
  logic nrst;

  int checks_cnt;
  int fail_cnt;

  gl_drive_unit_if #(.CHANNELS(CHANNELS), .DIV_WIDTH(DIV_WIDTH)) gl_bus ();

  gl_drive_unit #(
    .CHANNELS    (CHANNELS),
    .DIV_WIDTH   (DIV_WIDTH),
    .RST_PERIODS (RST_PERIODS)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .gl_if (gl_bus.slave)
  );

  // Free-running system clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare an observed value against a hand-computed expected value
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n rising edges and settle 1 unit after the last one
  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks_cnt      = 0;
    fail_cnt        = 0;
    nrst            = 1'b0;
    gl_bus.sync     = 1'b0;
    gl_bus.div      = 8'd0;
    gl_bus.ch_en    = 4'hF;
    gl_bus.rst_req  = 4'h0;

    // Reset state
    adv(3);
    check_eq("rst_gl_clk",  32'(gl_bus.gl_clk),  32'h0);
    check_eq("rst_gl_nrst", 32'(gl_bus.gl_nrst), 32'h0);
    check_eq("rst_aligned", 32'(gl_bus.aligned), 32'h0);

    // Power-up sequence with div=0. E0 is the last reset edge.
    nrst = 1'b1;
    adv(2);                                                        // E2
    check_eq("pu_clk_hi",   32'(gl_bus.gl_clk), 32'hF);
    adv(1);                                                        // E3
    check_eq("pu_clk_lo",   32'(gl_bus.gl_clk), 32'h0);
    adv(29);                                                       // E32
    check_eq("pu_nrst_hold", 32'(gl_bus.gl_nrst), 32'h0);
    check_eq("pu_aligned",   32'(gl_bus.aligned), 32'h0);
    adv(1);                                                        // E33
    check_eq("pu_nrst_rel", 32'(gl_bus.gl_nrst), 32'hF);

    // Sync rise with div=4. The sync rise lands on edge E34.
    gl_bus.div  = 8'd4;
    gl_bus.sync = 1'b1;
    adv(1);                                                        // E34
    gl_bus.sync = 1'b0;
    check_eq("sync_aligned", 32'(gl_bus.aligned), 32'h1);
    adv(1);                                                        // E35
    check_eq("sync_clk_lo", 32'(gl_bus.gl_clk), 32'h0);
    adv(4);                                                        // E39
    check_eq("div4_lo_end", 32'(gl_bus.gl_clk), 32'h0);
    adv(1);                                                        // E40
    check_eq("div4_rise",   32'(gl_bus.gl_clk), 32'hF);
    adv(4);                                                        // E44
    check_eq("div4_hi_end", 32'(gl_bus.gl_clk), 32'hF);
    adv(1);                                                        // E45
    check_eq("div4_fall",   32'(gl_bus.gl_clk), 32'h0);

    // Change div mid-half-period. The current low half still lasts 5 clocks.
    gl_bus.div = 8'd1;
    adv(4);                                                        // E49
    check_eq("divchg_lo5",  32'(gl_bus.gl_clk), 32'h0);
    adv(1);                                                        // E50
    check_eq("divchg_rise", 32'(gl_bus.gl_clk), 32'hF);
    adv(1);                                                        // E51
    check_eq("div1_hi2",    32'(gl_bus.gl_clk), 32'hF);
    adv(1);                                                        // E52
    check_eq("div1_fall",   32'(gl_bus.gl_clk), 32'h0);
    adv(2);                                                        // E54
    check_eq("div1_rise",   32'(gl_bus.gl_clk), 32'hF);
    check_eq("run_nrst",    32'(gl_bus.gl_nrst), 32'hF);

    // Second sync with div=0. B is the edge that applies it. aligned stays set.
    gl_bus.div  = 8'd0;
    gl_bus.sync = 1'b1;
    adv(1);                                                        // B
    gl_bus.sync = 1'b0;
    check_eq("sync2_aligned", 32'(gl_bus.aligned), 32'h1);

    // rst_req[2] in RUN. A second request coincides with a rise and restarts the count.
    gl_bus.rst_req = 4'h4;
    adv(1);                                                        // B+1
    gl_bus.rst_req = 4'h0;
    check_eq("req2_drop",   32'(gl_bus.gl_nrst), 32'hB);
    adv(11);                                                       // B+12
    gl_bus.rst_req = 4'h4;
    adv(1);                                                        // B+13
    gl_bus.rst_req = 4'h0;
    check_eq("req2_again",  32'(gl_bus.gl_nrst), 32'hB);
    adv(22);                                                       // B+35
    check_eq("req2_restart_hold", 32'(gl_bus.gl_nrst), 32'hB);
    adv(11);                                                       // B+46
    check_eq("req2_pre_rel", 32'(gl_bus.gl_nrst), 32'hB);
    adv(1);                                                        // B+47 = C
    check_eq("req2_rel",    32'(gl_bus.gl_nrst), 32'hF);

    // Disable channel 1 for 50 clocks, then re-enable it
    gl_bus.ch_en = 4'hD;
    adv(1);                                                        // C+1
    check_eq("dis1_nrst",   32'(gl_bus.gl_nrst), 32'hD);
    check_eq("dis1_clk",    32'(gl_bus.gl_clk),  32'hD);
    adv(49);                                                       // C+50
    check_eq("dis1_clk_held",  32'(gl_bus.gl_clk[1]), 32'h0);
    check_eq("dis1_nrst_held", 32'(gl_bus.gl_nrst),   32'hD);
    gl_bus.ch_en = 4'hF;
    adv(1);                                                        // C+51
    check_eq("en1_clk_phase", 32'(gl_bus.gl_clk), 32'hF);
    adv(32);                                                       // C+83
    check_eq("en1_nrst_hold", 32'(gl_bus.gl_nrst), 32'hD);
    adv(1);                                                        // C+84 = D
    check_eq("en1_nrst_rel",  32'(gl_bus.gl_nrst), 32'hF);

    // Put channel 0 into ALIGN, then assert nrst while the others are in RUN
    gl_bus.rst_req = 4'h1;
    adv(1);                                                        // D+1
    gl_bus.rst_req = 4'h0;
    check_eq("req0_drop",   32'(gl_bus.gl_nrst), 32'hE);
    adv(30);                                                       // D+31
    check_eq("pre_rst_clk", 32'(gl_bus.gl_clk),  32'hF);
    adv(1);                                                        // D+32, ch0 in ALIGN
    check_eq("pre_rst_nrst", 32'(gl_bus.gl_nrst), 32'hE);
    nrst = 1'b0;
    adv(1);                                                        // D+33
    check_eq("midrst_clk",     32'(gl_bus.gl_clk),  32'h0);
    check_eq("midrst_nrst",    32'(gl_bus.gl_nrst), 32'h0);
    check_eq("midrst_aligned", 32'(gl_bus.aligned), 32'h0);
    adv(1);                                                        // D+34
    nrst = 1'b1;

    // The power-up sequence repeats
    adv(32);
    check_eq("pu2_nrst_hold", 32'(gl_bus.gl_nrst), 32'h0);
    adv(1);
    check_eq("pu2_nrst_rel",  32'(gl_bus.gl_nrst), 32'hF);
    check_eq("pu2_aligned",   32'(gl_bus.aligned), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
